// File: rtl/ocean_game_engine_if.sv
// Handshake bundle between the ocean game engine and its frame/pixel driver.
// The master drives frame timing, controls and pixel position; the slave returns colour and game status.
interface ocean_game_engine_if;
  logic        frame_tick;
  logic        start;
  logic        up;
  logic        down;
  logic        left;
  logic        right;
  logic        bright;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [11:0] rgb;
  logic [3:0]  score;
  logic [1:0]  lives;
  logic [2:0]  game_state;

  modport master (
    output frame_tick, start, up, down, left, right, bright, hCount, vCount,
    input  rgb, score, lives, game_state
  );

  modport slave (
    input  frame_tick, start, up, down, left, right, bright, hCount, vCount,
    output rgb, score, lives, game_state
  );
endinterface

// File: rtl/ocean_game_engine.sv
// Game-state engine for the VGA ocean game: player, sharks, bottles, score/lives FSM
// and the registered pixel colour handed to the display controller.
//
// state  | meaning
// IDLE   | waiting for start, objects frozen
// PLAY   | player and objects move, collisions scored
// HIT    | recovery after a shark hit, player parked and blinking
// WIN    | score reached WIN_COUNT, frozen until start
// LOSE   | lives exhausted, frozen until start
module ocean_game_engine #(
  parameter int N_SHARK    = 4,
  parameter int N_BOTTLE   = 4,
  parameter int WIN_COUNT  = 8,
  parameter int LIVES      = 3,
  parameter int STEP       = 2,
  parameter int HIT_FRAMES = 30
) (
  input logic                clk,
  input logic                rst,
  ocean_game_engine_if.slave bus
);
  localparam int CW = $clog2(HIT_FRAMES + 1);

  localparam logic [9:0] PX0      = 10'd450;
  localparam logic [9:0] PY0      = 10'd250;
  localparam logic [9:0] X_MIN    = 10'd149;
  localparam logic [9:0] X_MAX    = 10'd778;
  localparam logic [9:0] Y_MIN    = 10'd40;
  localparam logic [9:0] Y_MAX    = 10'd410;
  localparam logic [9:0] WRAP_X   = 10'd153;
  localparam logic [9:0] RELOAD_X = 10'd774;
  localparam logic [9:0] STEP_W   = 10'(STEP);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  function automatic logic [9:0] shark_x0(input int i);
    return 10'(784 - 150 * i);
  endfunction

  function automatic logic [9:0] shark_y(input int i);
    return 10'(80 + 110 * i);
  endfunction

  function automatic logic [9:0] shark_spd(input int i);
    return 10'(1 + (i % 3));
  endfunction

  function automatic logic [9:0] bottle_x0(input int j);
    return 10'(200 + 140 * j);
  endfunction

  function automatic logic [9:0] bottle_y(input int j);
    return ((j % 2) == 0) ? 10'd440 : 10'(150 + 90 * j);
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] a, input logic [9:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [9:0] wrap_x(input logic [9:0] x);
    return (x <= WRAP_X) ? RELOAD_X : x;
  endfunction

  state_t        state_q, state_d;
  logic [9:0]    px_q, px_d, py_q, py_d;
  logic [9:0]    sx_q [N_SHARK];
  logic [9:0]    sx_d [N_SHARK];
  logic [9:0]    bx_q [N_BOTTLE];
  logic [9:0]    bx_d [N_BOTTLE];
  logic [3:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   rgb_q, rgb_d;

  logic                hit;
  logic [N_BOTTLE-1:0] col;
  logic [2:0]          n_col;
  logic [4:0]          score_sum;

  // Collisions use the registered (pre-move) positions of this tick.
  always_comb begin
    hit   = 1'b0;
    col   = '0;
    n_col = '0;
    for (int i = 0; i < N_SHARK; i++) begin
      if (absdiff(px_q, sx_q[i]) <= 10'd15 && absdiff(py_q, shark_y(i)) <= 10'd10)
        hit = 1'b1;
    end
    for (int j = 0; j < N_BOTTLE; j++) begin
      col[j] = (absdiff(px_q, bx_q[j]) <= 10'd7) && (absdiff(py_q, bottle_y(j)) <= 10'd9);
      n_col  = n_col + 3'(col[j]);
    end
  end

  assign score_sum = {1'b0, score_q} + {2'b00, n_col};

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    sx_d    = sx_q;
    bx_d    = bx_q;
    score_d = score_q;
    lives_d = lives_q;
    cnt_d   = cnt_q;
    if (bus.frame_tick) begin
      unique case (state_q)
        S_IDLE: if (bus.start) state_d = S_PLAY;
        S_PLAY: begin
          if (bus.up)         py_d = (py_q < Y_MIN + STEP_W) ? Y_MIN : py_q - STEP_W;
          else if (bus.down)  py_d = (py_q > Y_MAX - STEP_W) ? Y_MAX : py_q + STEP_W;
          if (bus.left)       px_d = (px_q < X_MIN + STEP_W) ? X_MIN : px_q - STEP_W;
          else if (bus.right) px_d = (px_q > X_MAX - STEP_W) ? X_MAX : px_q + STEP_W;
          for (int i = 0; i < N_SHARK; i++)
            sx_d[i] = wrap_x(sx_q[i] - shark_spd(i));
          for (int j = 0; j < N_BOTTLE; j++)
            bx_d[j] = (col[j] && !hit) ? RELOAD_X : wrap_x(bx_q[j] - 10'd1);
          if (hit) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = S_LOSE;
            end else begin
              state_d = S_HIT;
              cnt_d   = CW'(HIT_FRAMES);
              px_d    = PX0;
              py_d    = PY0;
            end
          end else if (score_sum >= 5'(WIN_COUNT)) begin
            score_d = 4'(WIN_COUNT);
            state_d = S_WIN;
          end else begin
            score_d = score_sum[3:0];
          end
        end
        S_HIT: begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = S_PLAY;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_WIN, S_LOSE: begin
          if (bus.start) begin
            state_d = S_IDLE;
            px_d    = PX0;
            py_d    = PY0;
            for (int i = 0; i < N_SHARK; i++)  sx_d[i] = shark_x0(i);
            for (int j = 0; j < N_BOTTLE; j++) bx_d[j] = bottle_x0(j);
            score_d = '0;
            lives_d = 2'(LIVES);
            cnt_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  logic in_player, in_sand, in_shark, in_bottle;

  always_comb begin
    in_shark  = 1'b0;
    in_bottle = 1'b0;
    for (int i = 0; i < N_SHARK; i++) begin
      if (absdiff(bus.hCount, sx_q[i]) <= 10'd10 && absdiff(bus.vCount, shark_y(i)) <= 10'd5)
        in_shark = 1'b1;
    end
    for (int j = 0; j < N_BOTTLE; j++) begin
      if (absdiff(bus.hCount, bx_q[j]) <= 10'd2 && absdiff(bus.vCount, bottle_y(j)) <= 10'd4)
        in_bottle = 1'b1;
    end
    in_player = (absdiff(bus.hCount, px_q) <= 10'd5) && (absdiff(bus.vCount, py_q) <= 10'd5);
    in_sand   = (bus.hCount >= 10'd144) && (bus.hCount <= 10'd784) &&
                (bus.vCount >= 10'd420) && (bus.vCount <= 10'd490);
    if (!bus.bright)               rgb_d = 12'h000;
    else if (in_player)            rgb_d = (state_q == S_HIT && cnt_q[0]) ? 12'hFFF : 12'hF00;
    else if (in_sand)              rgb_d = 12'hFF0;
    else if (in_shark)             rgb_d = 12'h058;
    else if (in_bottle)            rgb_d = 12'hAEF;
    else if (state_q == S_WIN)     rgb_d = 12'h0F0;
    else if (state_q == S_LOSE)    rgb_d = 12'h800;
    else                           rgb_d = 12'h0FF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      px_q    <= PX0;
      py_q    <= PY0;
      for (int i = 0; i < N_SHARK; i++)  sx_q[i] <= shark_x0(i);
      for (int j = 0; j < N_BOTTLE; j++) bx_q[j] <= bottle_x0(j);
      score_q <= '0;
      lives_q <= 2'(LIVES);
      cnt_q   <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      sx_q    <= sx_d;
      bx_q    <= bx_d;
      score_q <= score_d;
      lives_q <= lives_d;
      cnt_q   <= cnt_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.rgb        = rgb_q;
  assign bus.score      = score_q;
  assign bus.lives      = lives_q;
  assign bus.game_state = state_q;
endmodule

// File: tb/tb_ocean_game_engine.sv
// Scoreboard bench for ocean_game_engine: a behavioural game model predicts status per
// frame tick and colour per probed pixel; predictions are queued and compared on output.
module tb_ocean_game_engine;
  localparam int HIT_F   = 30;
  localparam int WIN_C   = 8;
  localparam int N_LIVES = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ocean_game_engine_if bus();

  ocean_game_engine #(
    .N_SHARK(4), .N_BOTTLE(4), .WIN_COUNT(WIN_C), .LIVES(N_LIVES), .STEP(2), .HIT_FRAMES(HIT_F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed { int kind; int val; } sb_item_t;
  sb_item_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // behavioural model
  int m_px, m_py, m_score, m_lives, m_state, m_cnt;
  int m_sx[4], m_sy[4], m_bx[4], m_by[4];

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  task automatic model_init();
    m_px = 450; m_py = 250;
    for (int i = 0; i < 4; i++) begin
      m_sx[i] = 784 - 150 * i;
      m_sy[i] = 80 + 110 * i;
      m_bx[i] = 200 + 140 * i;
      m_by[i] = (i % 2 == 0) ? 440 : 150 + 90 * i;
    end
    m_score = 0; m_lives = N_LIVES; m_state = 0; m_cnt = 0;
  endtask

  task automatic model_tick(input bit u, input bit d, input bit l, input bit r, input bit st);
    bit hit;
    bit col[4];
    int ncol;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        hit = 0; ncol = 0;
        for (int i = 0; i < 4; i++)
          if (iabs(m_px - m_sx[i]) <= 15 && iabs(m_py - m_sy[i]) <= 10) hit = 1;
        for (int j = 0; j < 4; j++) begin
          col[j] = (iabs(m_px - m_bx[j]) <= 7 && iabs(m_py - m_by[j]) <= 9);
          if (col[j]) ncol++;
        end
        if (u)      m_py = (m_py - 2 < 40) ? 40 : m_py - 2;
        else if (d) m_py = (m_py + 2 > 410) ? 410 : m_py + 2;
        if (l)      m_px = (m_px - 2 < 149) ? 149 : m_px - 2;
        else if (r) m_px = (m_px + 2 > 778) ? 778 : m_px + 2;
        for (int i = 0; i < 4; i++) begin
          m_sx[i] = m_sx[i] - (1 + i % 3);
          if (m_sx[i] <= 153) m_sx[i] = 774;
        end
        for (int j = 0; j < 4; j++) begin
          if (!hit && col[j]) m_bx[j] = 774;
          else begin
            m_bx[j] = m_bx[j] - 1;
            if (m_bx[j] <= 153) m_bx[j] = 774;
          end
        end
        if (hit) begin
          m_lives--;
          if (m_lives == 0) m_state = 4;
          else begin
            m_state = 2; m_cnt = HIT_F; m_px = 450; m_py = 250;
          end
        end else begin
          m_score = (m_score + ncol > WIN_C) ? WIN_C : m_score + ncol;
          if (m_score >= WIN_C) m_state = 3;
        end
      end
      2: begin
        m_cnt--;
        if (m_cnt == 0) m_state = 1;
      end
      default: if (st) model_init();
    endcase
  endtask

  function automatic int model_rgb(input int h, input int v, input bit b);
    if (!b) return 'h000;
    if (iabs(h - m_px) <= 5 && iabs(v - m_py) <= 5)
      return (m_state == 2 && (m_cnt % 2) == 1) ? 'hFFF : 'hF00;
    if (h >= 144 && h <= 784 && v >= 420 && v <= 490) return 'hFF0;
    for (int i = 0; i < 4; i++)
      if (iabs(h - m_sx[i]) <= 10 && iabs(v - m_sy[i]) <= 5) return 'h058;
    for (int j = 0; j < 4; j++)
      if (iabs(h - m_bx[j]) <= 2 && iabs(v - m_by[j]) <= 4) return 'hAEF;
    if (m_state == 3) return 'h0F0;
    if (m_state == 4) return 'h800;
    return 'h0FF;
  endfunction

  task automatic drain();
    sb_item_t it;
    while (sbq.size() > 0) begin
      it = sbq.pop_front();
      case (it.kind)
        0:       check_val("game_state", int'(bus.game_state), it.val);
        1:       check_val("score", int'(bus.score), it.val);
        2:       check_val("lives", int'(bus.lives), it.val);
        default: check_val("rgb", int'(bus.rgb), it.val);
      endcase
    end
  endtask

  task automatic tick(input bit u, input bit d, input bit l, input bit r, input bit st);
    bus.up = u; bus.down = d; bus.left = l; bus.right = r; bus.start = st;
    bus.frame_tick = 1'b1;
    model_tick(u, d, l, r, st);
    sbq.push_back(sb_item_t'{kind: 0, val: m_state});
    sbq.push_back(sb_item_t'{kind: 1, val: m_score});
    sbq.push_back(sb_item_t'{kind: 2, val: m_lives});
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    drain();
  endtask

  task automatic probe(input int h, input int v, input bit b);
    if (h < 0 || h > 1023 || v < 0 || v > 1023) return;
    bus.hCount = 10'(h); bus.vCount = 10'(v); bus.bright = b;
    sbq.push_back(sb_item_t'{kind: 3, val: model_rgb(h, v, b)});
    @(posedge clk); #1;
    drain();
  endtask

  task automatic probe_all();
    probe(m_px, m_py, 1);
    probe(m_px + 5, m_py, 1); probe(m_px + 6, m_py, 1);
    probe(m_px - 5, m_py, 1); probe(m_px - 6, m_py, 1);
    probe(m_px, m_py + 5, 1); probe(m_px, m_py + 6, 1);
    probe(m_px, m_py - 5, 1); probe(m_px, m_py - 6, 1);
    for (int i = 0; i < 4; i++) begin
      probe(m_sx[i], m_sy[i], 1);
      probe(m_sx[i] + 10, m_sy[i], 1); probe(m_sx[i] + 11, m_sy[i], 1);
      probe(m_sx[i] - 11, m_sy[i], 1); probe(m_sx[i], m_sy[i] + 6, 1);
    end
    for (int j = 0; j < 4; j++) begin
      probe(m_bx[j], m_by[j], 1);
      probe(m_bx[j] + 2, m_by[j] - 4, 1); probe(m_bx[j] + 3, m_by[j], 1);
    end
    probe(144, 420, 1); probe(784, 490, 1); probe(143, 450, 1);
    probe(785, 450, 1); probe(300, 419, 1); probe(300, 491, 1); probe(10, 10, 1);
  endtask

  task automatic run_until(input int target, input bit u, input bit d, input bit l, input bit r,
                           input int budget, input string tag);
    int n = 0;
    while (m_state != target && n < budget) begin
      tick(u, d, l, r, 1'b0);
      n++;
      if (n % 32 == 0) probe_all();
    end
    check_val(tag, int'(bus.game_state), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.frame_tick = 0; bus.start = 0; bus.up = 0; bus.down = 0; bus.left = 0; bus.right = 0;
    bus.bright = 1; bus.hCount = '0; bus.vCount = '0;
    model_init();
    #12;
    check_val("rst_rgb", int'(bus.rgb), 0);
    check_val("rst_score", int'(bus.score), 0);
    check_val("rst_lives", int'(bus.lives), N_LIVES);
    check_val("rst_state", int'(bus.game_state), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    probe_all();
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 0, 0);
    probe_all();
    tick(0, 0, 0, 0, 1);
    check_val("start_play", int'(bus.game_state), 1);
    tick(1, 0, 0, 0, 0);
    probe(450, 243, 1); probe(450, 242, 1);
    probe_all();

    for (int k = 0; k < 150; k++) tick(1, 0, 0, 0, 0);
    probe_all();
    probe(450, 35, 1); probe(450, 34, 1);
    for (int k = 0; k < 170; k++) tick(0, 0, 1, 0, 0);
    probe_all();
    for (int k = 0; k < 350; k++) tick(0, 0, 0, 1, 0);
    probe_all();

    run_until(2, 0, 1, 0, 0, 2500, "first_hit");
    check_val("hit_lives", int'(bus.lives), N_LIVES - 1);
    probe(450, 250, 1);
    for (int k = 0; k < HIT_F; k++) begin
      tick(0, 1, 1, 0, 0);
      if (k < 3 || k == HIT_F - 2 || k == HIT_F - 1) probe_all();
    end
    check_val("hit_recover", int'(bus.game_state), 1);

    run_until(4, 0, 1, 0, 0, 6000, "lose");
    check_val("lose_lives", int'(bus.lives), 0);
    probe(10, 10, 1);
    check_val("lose_bg", int'(bus.rgb), 'h800);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    check_val("restart_state", int'(bus.game_state), 0);
    check_val("restart_score", int'(bus.score), 0);
    check_val("restart_lives", int'(bus.lives), N_LIVES);
    probe_all();

    tick(0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0);
    run_until(3, 0, 0, 1, 0, 8000, "win");
    check_val("win_score", int'(bus.score), WIN_C);
    probe(10, 10, 1);
    check_val("win_bg", int'(bus.rgb), 'h0F0);
    probe_all();

    #2; rst = 1'b1;
    #1;
    check_val("async_rgb", int'(bus.rgb), 0);
    check_val("async_score", int'(bus.score), 0);
    check_val("async_lives", int'(bus.lives), N_LIVES);
    check_val("async_state", int'(bus.game_state), 0);
    @(negedge clk); rst = 1'b0;
    model_init();
    @(posedge clk); #1;

    tick(0, 0, 0, 0, 1);
    probe(450, 250, 0);
    probe(450, 250, 1);
    probe_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ocean_game_engine.md
# ocean_game_engine

Parametrised game-state engine for the VGA ocean game. It owns the player block, N_SHARK hazards, N_BOTTLE collectibles, score, lives and a five-state game FSM, and generates the pixel colour for the display controller. Object motion advances once per `frame_tick` enable on the single `clk` domain. It replaces the fixed two-shark, two-bottle controller with configurable object counts, lives, a hit-recovery phase and win/lose terminal states.

## Interface
- N_SHARK, 4: number of hazards, 1..4.
- N_BOTTLE, 4: number of collectibles, 1..4.
- WIN_COUNT, 8: score that ends the game in WIN, 1..15.
- LIVES, 3: starting lives, 1..3.
- STEP, 2: player pixels moved per frame tick.
- HIT_FRAMES, 30: frame ticks spent in HIT before play resumes.
- clk  in  1  system clock; pixel-rate counters arrive on it.
- rst  in  1  reset, asynchronous, active-high.
- frame_tick  in  1  one-cycle pulse, once per frame; all motion and FSM frame actions are gated by it.
- start  in  1  level; moves the FSM IDLE→PLAY and WIN/LOSE→IDLE.
- up, down, left, right  in  1  each  player direction, level-sensitive.
- bright  in  1  display-area flag.
- hCount, vCount  in  10 each  current pixel position.
- rgb  out  12  registered pixel colour.
- score  out  4  bottles collected.
- lives  out  2  remaining lives.
- game_state  out  3  encoding: IDLE=0, PLAY=1, HIT=2, WIN=3, LOSE=4.

## Operation
- **Reset/init values:**
  - Player at (450,250).
  - Shark i at x=784−150·i, y=80+110·i. Speed is 1+(i mod 3) px/tick, moving leftward.
  - Bottle j at x=200+140·j, y=440 when j is even and 150+90·j when j is odd. Speed is 1 px/tick, moving leftward.
  - score=0, lives=LIVES, game_state=IDLE, rgb=0, hit counter=0.
- **Wrap:**
  - An object whose x is ≤153 after its move reloads x=774 on the same tick; y is unchanged.
  - A collected bottle reloads x=774 on the tick of collection.
- **Player motion (PLAY only):**
  - Vertical: up takes priority over down.
  - Horizontal: left takes priority over right.
  - One vertical and one horizontal move are allowed per tick.
  - Position is clamped to x∈[149,778] and y∈[40,410]; the sand band is not enterable.
- **Collision tests:** evaluated on the pre-update registered positions at each PLAY tick, using unsigned absolute differences.
  - Shark hit: |px−sx|≤15 and |py−sy|≤10.
  - Bottle collect: |px−bx|≤7 and |py−by|≤9.
- **IDLE:** all objects are frozen. Any tick with start=1 enters PLAY.
- **PLAY:**
  - On each tick, move the player and all objects, then evaluate in this priority order.
  - Shark hit (any shark): lives−1. If the result is 0, go to LOSE; otherwise go to HIT and load the hit counter with HIT_FRAMES.
  - On a hit tick, bottle collection is suppressed.
  - Otherwise: score += number of bottles collected this tick, saturating at WIN_COUNT. If the new score is ≥WIN_COUNT, go to WIN.
- **HIT:**
  - Entering HIT resets the player to (450,250); sharks and bottles are frozen.
  - The counter decrements once per tick. When it reaches 0, return to PLAY.
  - Inputs are ignored.
- **WIN/LOSE:**
  - Everything is frozen.
  - A tick with start=1 goes to IDLE and reloads all init values, including score and lives.
- **Colour priority:**
  1. ~bright → 0x000.
  2. Player: 11×11 box; 0xF00, or 0xFFF on odd hit-counter values during HIT.
  3. Sand band, h 144..784 × v 420..490: 0xFF0.
  4. Shark: 21×11 box: 0x058.
  5. Bottle: 5×9 box: 0xAEF.
  6. Background: PLAY/IDLE/HIT 0x0FF, WIN 0x0F0, LOSE 0x800.
- Objects with index ≥ N_SHARK or ≥ N_BOTTLE do not exist: no logic, no pixels.

## Timing
- rgb has a latency of one clk cycle from hCount/vCount/bright.
- State, positions, score and lives update on the clk edge where frame_tick=1. Between ticks they hold.
- start and direction inputs are sampled only on tick cycles.
- Simultaneous hits on several sharks in one tick cost 1 life only.
- Bottles collected on the same tick each count toward score.
- rst asserted mid-game returns every output to its reset value asynchronously.
- rgb=0 while rst is high.

## Test plan
- Reset, then start on one tick → game_state=1 on the following cycle. The player moves (450,250)→(450,248) after one tick with up=1.
- Hold up for 300 ticks → player y stops at 40 and never underflows. Hold down → y stops at 410.
- Place the player on a shark path with LIVES=3 → lives=2 and game_state=2. After exactly 30 ticks game_state=1, and the player is at (450,250) during HIT.
- Take three hits with LIVES=3 → game_state=4 with lives=0. Start → IDLE with score=0 and lives=3.
- Two bottles overlap the player on the same tick with score=7 and WIN_COUNT=8 → score=8 (saturated), game_state=3, background=0x0F0.
- Shark and bottle overlap on the same tick → lives decrements and score is unchanged. Shark 0 starting at x=154 moves to 153 and then wraps to 774.
